// File: rtl/reorder_fifo.sv
// reorder_fifo: in-order dispatch-to-commit instruction FIFO with flush on commit-abort.
// Optional high-water-mark register enabled by defining REORDER_FIFO_HWM_EN.
module reorder_fifo #(
    parameter int RNBIT = 2,
    parameter int DP = 16,
    localparam int AW = $clog2(DP),
    localparam int DW = 64 + 5 + RNBIT + 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_valid_i,
    input  logic [DW-1:0] push_info_i,
    output logic          push_ready_o,
    output logic          pop_valid_o,
    output logic [DW-1:0] pop_info_o,
    input  logic          pop_ready_i,
    output logic [AW:0]   count_o,
    output logic [AW:0]   hwm_o
);
    logic [DW-1:0] mem_q [DP];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic empty, full, push_fire, pop_fire;
    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push_fire = push_valid_i & ~full & ~flush_i;
    assign pop_fire = pop_ready_i & ~empty & ~flush_i;
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_fire};
        rd_ptr_d = flush_i ? wr_ptr_q : rd_ptr_q + {{AW{1'b0}}, pop_fire};
        count_d = wr_ptr_d - rd_ptr_d;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_fire) mem_q[wr_ptr_q[AW-1:0]] <= push_info_i;
    end
    assign push_ready_o = ~full;
    assign pop_valid_o = ~empty;
    assign pop_info_o = mem_q[rd_ptr_q[AW-1:0]];
    assign count_o = count_q;
`ifdef REORDER_FIFO_HWM_EN
    logic [AW:0] hwm_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) hwm_q <= '0;
        else if (count_d > hwm_q) hwm_q <= count_d;
    end
    assign hwm_o = hwm_q;
`else
    assign hwm_o = '0;
`endif
endmodule

// File: tb/tb_reorder_fifo.sv
// tb_reorder_fifo: table vectors, directed corner sequences and random traffic against a queue model.
module tb_reorder_fifo;
    localparam int DP = 16;
    localparam int AW = 4;
    localparam int DW = 73;
`ifdef REORDER_FIFO_HWM_EN
    localparam bit HWM = 1'b1;
`else
    localparam bit HWM = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, pv = 1'b0, pr = 1'b0;
    logic [DW-1:0] pinfo = '0;
    logic push_ready, pop_valid;
    logic [DW-1:0] pop_info;
    logic [AW:0] count, hwm;
    int checks = 0, failures = 0;
    logic [DW-1:0] q[$];
    int hwm_m = 0;

    always #5 clk = ~clk;

    reorder_fifo #(.RNBIT(2), .DP(DP)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .push_valid_i(pv), .push_info_i(pinfo), .push_ready_o(push_ready),
        .pop_valid_o(pop_valid), .pop_info_o(pop_info), .pop_ready_i(pr),
        .count_o(count), .hwm_o(hwm)
    );

    typedef struct {
        logic pv, pr, fl;
        logic [63:0] pc;
        logic [6:0] rd;
        int cnt;
        logic vld, rdy;
        logic [63:0] hpc;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [DW-1:0] mk(logic [63:0] pc, logic [6:0] rd);
        return {pc, rd, pc[2], pc[3]};
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle; the queue model applies the FIFO rules and all outputs are compared after the edge.
    task automatic tick(logic v, logic [DW-1:0] info, logic r, logic f);
        bit pf, of;
        pv = v; pinfo = info; pr = r; flush = f;
        if (q.size() > 0) chk("head_pre", pop_info, q[0]);
        pf = v && q.size() < DP && !f;
        of = r && q.size() > 0 && !f;
        @(posedge clk); #1;
        if (f) q.delete();
        else begin
            if (of) void'(q.pop_front());
            if (pf) q.push_back(info);
        end
        if (q.size() > hwm_m) hwm_m = q.size();
        chk("count", count, q.size());
        chk("pop_valid", pop_valid, q.size() != 0);
        chk("push_ready", push_ready, q.size() < DP);
        chk("hwm", hwm, HWM ? hwm_m : 0);
    endtask

    task automatic do_reset();
        pv = 0; pr = 0; flush = 0; rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        q.delete();
        hwm_m = 0;
        chk("rst_count", count, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_push_ready", push_ready, 1);
        chk("rst_hwm", hwm, 0);
    endtask

    initial begin
        int pushed;
        tbl[0]  = '{1, 0, 0, 64'h80000000, 7'd5, 1, 1, 1, 64'h80000000};
        tbl[1]  = '{1, 0, 0, 64'h80000004, 7'd6, 2, 1, 1, 64'h80000000};
        tbl[2]  = '{1, 0, 0, 64'h80000008, 7'd7, 3, 1, 1, 64'h80000000};
        tbl[3]  = '{0, 1, 0, 64'h0, 7'd0, 2, 1, 1, 64'h80000004};
        tbl[4]  = '{0, 1, 0, 64'h0, 7'd0, 1, 1, 1, 64'h80000008};
        tbl[5]  = '{0, 1, 0, 64'h0, 7'd0, 0, 0, 1, 64'h0};
        tbl[6]  = '{0, 1, 0, 64'h0, 7'd0, 0, 0, 1, 64'h0};
        tbl[7]  = '{1, 0, 1, 64'hDEAD, 7'd1, 0, 0, 1, 64'h0};
        tbl[8]  = '{1, 0, 0, 64'h100, 7'd2, 1, 1, 1, 64'h100};
        tbl[9]  = '{1, 1, 0, 64'h104, 7'd3, 1, 1, 1, 64'h104};
        tbl[10] = '{0, 0, 1, 64'h0, 7'd0, 0, 0, 1, 64'h0};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            tick(tbl[i].pv, mk(tbl[i].pc, tbl[i].rd), tbl[i].pr, tbl[i].fl);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("tbl%0d_valid", i), pop_valid, tbl[i].vld);
            chk($sformatf("tbl%0d_ready", i), push_ready, tbl[i].rdy);
            if (tbl[i].vld) chk($sformatf("tbl%0d_head", i), pop_info[DW-1 -: 64], tbl[i].hpc);
        end

        do_reset();
        for (int i = 0; i < DP; i++) tick(1, mk(64'h1000 + 4 * i, 7'(i)), 0, 0);
        chk("fill_count", count, 16);
        chk("fill_ready", push_ready, 0);
        tick(1, mk(64'hDEAD, 7'd9), 0, 0);
        chk("push17_count", count, 16);
        tick(1, mk(64'hBEEF, 7'd9), 1, 0);
        chk("fullpp_count", count, 15);
        chk("fullpp_head", pop_info[DW-1 -: 64], 64'h1004);
        for (int i = 0; i < 15; i++) tick(0, '0, 1, 0);
        chk("drain_valid", pop_valid, 0);

        do_reset();
        for (int i = 0; i < 7; i++) tick(1, mk(64'h1800 + 4 * i, 7'(i)), 0, 0);
        tick(1, mk(64'hBAD0, 7'd1), 1, 1);
        chk("flush_count", count, 0);
        chk("flush_valid", pop_valid, 0);
        chk("flush_ready", push_ready, 1);
        tick(1, mk(64'h2000, 7'd4), 0, 0);
        chk("postflush_head", pop_info[DW-1 -: 64], 64'h2000);

        do_reset();
        for (int i = 0; i < 9; i++) tick(1, mk(64'h2800 + 4 * i, 7'(i)), 0, 0);
        pv = 1;
        #2 rst_n = 0;
        #1;
        chk("async_count", count, 0);
        chk("async_valid", pop_valid, 0);
        chk("async_ready", push_ready, 1);
        q.delete();
        hwm_m = 0;
        @(posedge clk); #1;
        rst_n = 1;
        tick(1, mk(64'h3000, 7'd3), 0, 0);
        chk("relpush_count", count, 1);

        do_reset();
        for (int i = 0; i < 12; i++) tick(1, mk(64'h4000 + 4 * i, 7'(i)), 0, 0);
        for (int i = 0; i < 12; i++) tick(0, '0, 1, 0);
        tick(0, '0, 0, 1);
        for (int i = 0; i < 3; i++) tick(1, mk(64'h5000 + 4 * i, 7'(i)), 0, 0);
        chk("hwm_plan", hwm, HWM ? 12 : 0);

        do_reset();
        pushed = 0;
        for (int c = 0; c < 400 && (pushed < 40 || q.size() > 0); c++) begin
            logic v;
            v = pushed < 40 && q.size() < 4 && $urandom_range(0, 2) != 0;
            tick(v, mk(64'h6000 + 4 * pushed, 7'(pushed)), $urandom_range(0, 2) != 0, 0);
            if (v) pushed++;
        end
        chk("wrap_pushed", pushed, 40);
        chk("wrap_empty", pop_valid, 0);

        for (int c = 0; c < 600; c++)
            tick($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom},
                 $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
